conv3x3_stream: RTL and testbench

//  Upstream stage of the max-pool block. Holds a 3x3 kernel and an IN_SIZE x IN_SIZE

---
 rtl/conv3x3_stream_if.sv | 22 ++
 rtl/conv3x3_stream.sv | 151 +++++++++++++++
 tb/tb_conv3x3_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_if.sv
// Handshake/bus bundle between a driver (load/start side) and the conv3x3_stream core.
interface conv3x3_if;
  logic        load_w;
  logic [7:0]  w_in;
  logic        load_px;
  logic [7:0]  px_in;
  logic        start;
  logic [15:0] conv_out;
  logic        conv_valid;
  logic        busy;
  logic        done_conv;

  modport master (
    output load_w, w_in, load_px, px_in, start,
    input  conv_out, conv_valid, busy, done_conv
  );

  modport slave (
    input  load_w, w_in, load_px, px_in, start,
    output conv_out, conv_valid, busy, done_conv
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Serially loaded 3x3 kernel + IN_SIZE^2 tile; valid stride-1 convolution with one
// multiplier (9 MAC cycles + 1 emit cycle per output word), saturated to 16 bits.
//
// state | meaning
// IDLE  | after reset; loads accepted, waiting for start
// MAC   | accumulating kernel tap (r_kr, r_kc) for output (r_r, r_c)
// EMIT  | registering saturated result, advancing to next output
// DONE  | pass complete; loads accepted, start re-runs
module conv3x3_stream #(
  parameter int N       = 3,
  parameter int SIZE    = 2 * N,
  parameter int IN_SIZE = SIZE + 2
) (
  input logic       i_clk,
  input logic       i_reset,
  conv3x3_if.slave  bus
);

  localparam int PX_N = IN_SIZE * IN_SIZE;
  localparam int PX_W = $clog2(PX_N);
  localparam int RC_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_w  [9];
  logic [7:0]        r_px [PX_N];
  logic [3:0]        r_widx;
  logic [PX_W-1:0]   r_pxidx;
  logic [RC_W-1:0]   r_r, r_c;
  logic [1:0]        r_kr, r_kc;
  logic [19:0]       r_acc;
  logic [15:0]       r_conv_out;
  logic              r_conv_valid;

  logic              w_open;
  logic              w_start_ok;
  logic              w_last_tap;
  logic              w_last_out;
  logic [3:0]        w_ki;
  logic [PX_W-1:0]   w_pa;
  logic [15:0]       w_prod;
  logic              w_busy;
  logic              w_done;

  assign w_open     = (r_state == IDLE) || (r_state == DONE);
  assign w_start_ok = w_open && bus.start;
  assign w_last_tap = (r_kr == 2'd2) && (r_kc == 2'd2);
  assign w_last_out = (r_r == RC_W'(SIZE - 1)) && (r_c == RC_W'(SIZE - 1));

  assign w_ki   = ({2'b00, r_kr} * 4'd3) + {2'b00, r_kc};
  assign w_pa   = ((PX_W'(r_r) + PX_W'(r_kr)) * PX_W'(IN_SIZE)) + PX_W'(r_c) + PX_W'(r_kc);
  assign w_prod = 16'(r_w[w_ki]) * 16'(r_px[w_pa]);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_next = MAC;
      MAC: begin
        w_busy = 1'b1;
        if (w_last_tap) w_next = EMIT;
      end
      EMIT: begin
        w_busy = 1'b1;
        w_next = w_last_out ? DONE : MAC;
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.start) w_next = MAC;
      end
      default: w_next = IDLE;
    endcase
  end

  // Memories are deliberately outside the reset domain: reset does not clear them.
  always_ff @(posedge i_clk) begin
    if (w_open && bus.load_w)  r_w[r_widx]    <= bus.w_in;
    if (w_open && bus.load_px) r_px[r_pxidx]  <= bus.px_in;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_widx  <= '0;
      r_pxidx <= '0;
    end else if (w_start_ok) begin
      r_widx  <= '0;
      r_pxidx <= '0;
    end else if (w_open) begin
      if (bus.load_w)  r_widx  <= (r_widx == 4'd8) ? 4'd0 : r_widx + 4'd1;
      if (bus.load_px) r_pxidx <= (r_pxidx == PX_W'(PX_N - 1)) ? '0 : r_pxidx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_r          <= '0;
      r_c          <= '0;
      r_kr         <= '0;
      r_kc         <= '0;
      r_acc        <= '0;
      r_conv_out   <= '0;
      r_conv_valid <= 1'b0;
    end else begin
      r_conv_valid <= 1'b0;
      case (r_state)
        MAC: begin
          r_acc <= r_acc + 20'(w_prod);
          if (r_kc == 2'd2) begin
            r_kc <= '0;
            r_kr <= w_last_tap ? 2'd0 : r_kr + 2'd1;
          end else begin
            r_kc <= r_kc + 2'd1;
          end
        end
        EMIT: begin
          r_conv_out   <= (r_acc > 20'h0FFFF) ? 16'hFFFF : r_acc[15:0];
          r_conv_valid <= 1'b1;
          r_acc        <= '0;
          if (r_c == RC_W'(SIZE - 1)) begin
            r_c <= '0;
            r_r <= r_r + 1'b1;
          end else begin
            r_c <= r_c + 1'b1;
          end
        end
        default: begin
          if (w_start_ok) begin
            r_r   <= '0;
            r_c   <= '0;
            r_kr  <= '0;
            r_kc  <= '0;
            r_acc <= '0;
          end
        end
      endcase
    end
  end

  assign bus.conv_out   = r_conv_out;
  assign bus.conv_valid = r_conv_valid;
  assign bus.busy       = w_busy;
  assign bus.done_conv  = w_done;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed + randomized checks of conv3x3_stream against an array-based convolution model.
module tb_conv3x3_stream;
  logic clk = 1'b0;
  logic rst;
  conv3x3_if bus();

  conv3x3_stream dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m_w  [9];
  int m_px [64];
  int m_widx  = 0;
  int m_pxidx = 0;
  int exp_q[$];
  int got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ld_w(input int v);
    bus.w_in   = 8'(v);
    bus.load_w = 1'b1;
    tick();
    bus.load_w = 1'b0;
    m_w[m_widx] = v;
    m_widx = (m_widx + 1) % 9;
  endtask

  task automatic ld_px(input int v, input bit with_start);
    bus.px_in   = 8'(v);
    bus.load_px = 1'b1;
    bus.start   = with_start;
    tick();
    bus.load_px = 1'b0;
    bus.start   = 1'b0;
    m_px[m_pxidx] = v;
    m_pxidx = (m_pxidx + 1) % 64;
    if (with_start) begin
      m_widx  = 0;
      m_pxidx = 0;
    end
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_widx  = 0;
    m_pxidx = 0;
  endtask

  // Plain valid convolution over the model memories, saturated to 16 bits.
  task automatic build_exp;
    exp_q.delete();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        int s = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            s += m_w[kr*3+kc] * m_px[(r+kr)*8 + c + kc];
        exp_q.push_back(s > 65535 ? 65535 : s);
      end
  endtask

  // Called one tick after the start edge; cyc counts clock edges since that edge.
  task automatic run_pass(input string tag, input bit disturb);
    int n = 0;
    int done_cyc = -1;
    got_q.delete();
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      if (disturb) begin
        bus.start   = (cyc == 25);
        bus.load_px = (cyc == 25 || cyc == 137 || cyc == 250);
        bus.px_in   = 8'hAA;
      end
      tick();
      if (bus.conv_valid) begin
        chk({tag, "_spacing"}, cyc, 10 * (n + 1));
        chk({tag, "_data"}, 32'(bus.conv_out), (n < exp_q.size()) ? exp_q[n] : -1);
        got_q.push_back(int'(bus.conv_out));
        n++;
      end
      if (cyc == 5) begin
        chk({tag, "_busy_mid"}, 32'(bus.busy), 1);
        chk({tag, "_done_mid"}, 32'(bus.done_conv), 0);
      end
      if (bus.done_conv) done_cyc = cyc;
    end
    bus.start   = 1'b0;
    bus.load_px = 1'b0;
    chk({tag, "_count"}, n, 36);
    chk({tag, "_done_cyc"}, done_cyc, 360);
    chk({tag, "_busy_end"}, 32'(bus.busy), 0);
    tick();
    chk({tag, "_done_hold"}, 32'(bus.done_conv), 1);
    chk({tag, "_valid_end"}, 32'(bus.conv_valid), 0);
    chk({tag, "_out_hold"}, 32'(bus.conv_out), exp_q[35]);
  endtask

  initial begin
    int nv;
    rst         = 1'b1;
    bus.load_w  = 1'b0;
    bus.w_in    = '0;
    bus.load_px = 1'b0;
    bus.px_in   = '0;
    bus.start   = 1'b0;
    repeat (3) tick();
    chk("rst_out",   32'(bus.conv_out), 0);
    chk("rst_valid", 32'(bus.conv_valid), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done_conv), 0);
    rst = 1'b0;
    tick();

    // all ones kernel over constant 2 tile
    for (int i = 0; i < 9; i++)  ld_w(1);
    for (int i = 0; i < 64; i++) ld_px(2, 1'b0);
    build_exp();
    do_start();
    run_pass("s1", 1'b0);
    chk("s1_first", got_q.size() > 0 ? got_q[0] : -1, 18);

    // identity kernel, ramp tile
    for (int i = 0; i < 9; i++)  ld_w(i == 4 ? 1 : 0);
    for (int i = 0; i < 64; i++) ld_px(i, 1'b0);
    build_exp();
    do_start();
    run_pass("s2", 1'b0);
    chk("s2_first", got_q.size() > 0 ? got_q[0] : -1, 9);
    chk("s2_last",  got_q.size() > 0 ? got_q[got_q.size()-1] : -1, 54);

    // saturation
    for (int i = 0; i < 9; i++)  ld_w(255);
    for (int i = 0; i < 64; i++) ld_px(255, 1'b0);
    build_exp();
    do_start();
    run_pass("s3", 1'b0);
    chk("s3_sat", got_q.size() > 0 ? got_q[0] : -1, 65535);

    // random data; start and loads while busy must not disturb the pass or memories
    for (int i = 0; i < 9; i++)  ld_w(int'($urandom_range(0, 255)));
    for (int i = 0; i < 64; i++) ld_px(int'($urandom_range(0, 255)), 1'b0);
    build_exp();
    do_start();
    run_pass("s4", 1'b1);
    do_start();
    run_pass("s4b", 1'b0);

    // reset during 5th MAC of the third output
    for (int i = 0; i < 9; i++)  ld_w(1);
    for (int i = 0; i < 64; i++) ld_px(2, 1'b0);
    build_exp();
    do_start();
    repeat (24) tick();
    chk("s5_busy_pre", 32'(bus.busy), 1);
    chk("s5_out_pre",  32'(bus.conv_out), 18);
    rst = 1'b1;
    #1;
    chk("s5_rst_valid", 32'(bus.conv_valid), 0);
    chk("s5_rst_out",   32'(bus.conv_out), 0);
    chk("s5_rst_busy",  32'(bus.busy), 0);
    chk("s5_rst_done",  32'(bus.done_conv), 0);
    #1;
    rst = 1'b0;
    m_widx  = 0;
    m_pxidx = 0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.conv_valid) nv++;
    end
    chk("s5_quiet", nv, 0);
    chk("s5_idle_busy", 32'(bus.busy), 0);
    do_start();
    run_pass("s5", 1'b0);

    // weight index wrap overwrites w[0], w[1]; start together with last pixel
    for (int i = 0; i < 11; i++) ld_w(int'($urandom_range(0, 255)));
    for (int i = 0; i < 63; i++) ld_px(int'($urandom_range(0, 255)), 1'b0);
    ld_px(int'($urandom_range(0, 255)), 1'b1);
    build_exp();
    run_pass("s6", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
